// File: rtl/pc_fetch_ctrl_if.sv
// Instruction-memory fetch handshake between pc_fetch_ctrl (master) and the memory (slave).
interface pc_fetch_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;

    modport master (output imem_req, output imem_addr, input imem_ack);
    modport slave  (input imem_req, input imem_addr, output imem_ack);
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC sequencer / fetch controller with redirect squash and halt/resume.
// Optional saturating fetch counter enabled by PC_FETCH_PERF_CNT_EN.
module pc_fetch_ctrl #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    pc_fetch_ctrl_if.master     imem,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [WIDTH-1:0]    redirect_target,
    input  logic                halt_req,
    input  logic                resume,
    output logic                instr_valid,
    output logic [WIDTH-1:0]    instr_pc,
`ifdef PC_FETCH_PERF_CNT_EN
    output logic [15:0]         fetch_count,
`endif
    output logic                halted
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FETCH  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_tgt;
    logic             r_out;
    logic             r_squash;
    logic             r_halt_pend;
    logic             r_valid;
    logic [WIDTH-1:0] r_ipc;

    logic             w_req;
    logic             w_ack;
    logic             w_halt;
    logic [WIDTH-1:0] w_tgt;

    // A request presented this cycle counts as in flight, so the address never moves under it.
    assign w_req  = (r_state == S_FETCH) && (!stall || r_out);
    assign w_ack  = w_req && imem.imem_ack;
    assign w_halt = halt_req || r_halt_pend;
    assign w_tgt  = redirect_target & ~WIDTH'(3);

    assign imem.imem_req  = w_req;
    assign imem.imem_addr = r_pc;
    assign instr_valid    = r_valid;
    assign instr_pc       = r_ipc;
    assign halted         = (r_state == S_HALTED);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_pc        <= RESET_PC;
            r_tgt       <= '0;
            r_out       <= 1'b0;
            r_squash    <= 1'b0;
            r_halt_pend <= 1'b0;
            r_valid     <= 1'b0;
            r_ipc       <= '0;
        end else begin
            r_valid <= 1'b0;
            r_out   <= w_req && !imem.imem_ack;

            if (redirect_valid) begin
                if (w_req && !imem.imem_ack) begin
                    r_tgt    <= w_tgt;
                    r_squash <= 1'b1;
                end else begin
                    r_pc     <= w_tgt;
                    r_squash <= 1'b0;
                end
            end else if (w_ack) begin
                if (r_squash) begin
                    r_pc     <= r_tgt;
                    r_squash <= 1'b0;
                end else begin
                    r_valid <= 1'b1;
                    r_ipc   <= r_pc;
                    r_pc    <= r_pc + WIDTH'(4);
                end
            end

            // Halt waits for an in-flight request to complete; the pending flag remembers a short halt_req.
            case (r_state)
                S_IDLE:   r_state <= S_FETCH;
                S_FETCH: begin
                    if (w_halt) begin
                        if (!w_req || imem.imem_ack) begin
                            r_state     <= S_HALTED;
                            r_halt_pend <= 1'b0;
                        end else begin
                            r_halt_pend <= 1'b1;
                        end
                    end
                end
                S_HALTED: if (!halt_req && resume) r_state <= S_FETCH;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

`ifdef PC_FETCH_PERF_CNT_EN
    logic [15:0] r_cnt;
    logic        w_deliver;

    assign w_deliver   = w_ack && !redirect_valid && !r_squash;
    assign fetch_count = r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_deliver && (r_cnt != 16'hFFFF)) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end
`endif

endmodule
